// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB register: drives a req/ack data port,
// stalls upstream while waiting, aborts on timeout, exports writeback.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   exec_in              ALU result / memory address
//   store_data_in        store data
//   write_reg_in         destination register
//   mem_write_in         store
//   mem_read_in          load
//   mem_to_reg_in        writeback load data instead of exec_in
//   reg_write_in         register-file write enable
//   dmem_req/we/addr/wdata  data-memory request (latched while BUSY)
//   dmem_rdata/ack       data-memory response
//   stall                holds upstream stages (combinational)
//   wb_data/reg/reg_write  MEM/WB register outputs
//   fwd_valid            writeback usable for forwarding (not XZR)
//   bus_err              sticky misalign/timeout flag

module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] exec_in,
    input  logic [63:0] store_data_in,
    input  logic [4:0]  write_reg_in,
    input  logic        mem_write_in,
    input  logic        mem_read_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_reg_write,
    output logic        fwd_valid,
    output logic        bus_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        m2r_q, m2r_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        wb_we_q, wb_we_d;
    logic        err_q, err_d;
    logic        stall_c;
    logic        access;
    logic        misaligned;

    assign access     = mem_read_in | mem_write_in;
    assign misaligned = access & (exec_in[2:0] != 3'd0);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        m2r_d     = m2r_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_reg_d  = wb_reg_q;
        wb_we_d   = wb_we_q;
        err_d     = err_q;
        stall_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (!access) begin
                    wb_data_d = exec_in;
                    wb_reg_d  = write_reg_in;
                    wb_we_d   = reg_write_in;
                end else if (misaligned) begin
                    // No bus cycle; a dropped load returns zero.
                    wb_data_d = mem_to_reg_in ? 64'd0 : exec_in;
                    wb_reg_d  = write_reg_in;
                    wb_we_d   = reg_write_in;
                    err_d     = 1'b1;
                end else begin
                    addr_d  = exec_in;
                    wdata_d = store_data_in;
                    we_d    = mem_write_in;
                    rd_d    = write_reg_in;
                    rw_d    = reg_write_in;
                    m2r_d   = mem_to_reg_in;
                    state_d = BUSY;
                    stall_c = 1'b1;
                    wb_we_d = 1'b0;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    wb_data_d = m2r_q ? dmem_rdata : addr_q;
                    wb_reg_d  = rd_q;
                    wb_we_d   = rw_q;
                    state_d   = IDLE;
                    cnt_d     = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: complete as if acked with zero data.
                    wb_data_d = m2r_q ? 64'd0 : addr_q;
                    wb_reg_d  = rd_q;
                    wb_we_d   = rw_q;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = 8'd0;
                end else begin
                    stall_c = 1'b1;
                    wb_we_d = 1'b0;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            we_q      <= 1'b0;
            rd_q      <= 5'd0;
            rw_q      <= 1'b0;
            m2r_q     <= 1'b0;
            cnt_q     <= 8'd0;
            wb_data_q <= 64'd0;
            wb_reg_q  <= 5'd0;
            wb_we_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            m2r_q     <= m2r_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_reg_q  <= wb_reg_d;
            wb_we_q   <= wb_we_d;
            err_q     <= err_d;
        end
    end

    // Reset forces stall low even though the decode is combinational.
    assign stall        = stall_c & rst_n;
    assign dmem_req     = (state_q == BUSY);
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign wb_data      = wb_data_q;
    assign wb_reg       = wb_reg_q;
    assign wb_reg_write = wb_we_q;
    assign fwd_valid    = wb_we_q & (wb_reg_q != 5'd31);
    assign bus_err      = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (TIMEOUT=4).
// Inputs change 1 time unit after the rising edge.

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] exec_in = '0;
    logic [63:0] store_data_in = '0;
    logic [4:0]  write_reg_in = '0;
    logic        mem_write_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_to_reg_in = 1'b0;
    logic        reg_write_in = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        stall;
    logic [63:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_reg_write;
    logic        fwd_valid;
    logic        bus_err;

    int vecs = 0;
    int errs = 0;

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .exec_in      (exec_in),
        .store_data_in(store_data_in),
        .write_reg_in (write_reg_in),
        .mem_write_in (mem_write_in),
        .mem_read_in  (mem_read_in),
        .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in (reg_write_in),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall        (stall),
        .wb_data      (wb_data),
        .wb_reg       (wb_reg),
        .wb_reg_write (wb_reg_write),
        .fwd_valid    (fwd_valid),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [63:0] ex, input logic [63:0] sd,
                      input logic [4:0] rd, input logic mw, input logic mr,
                      input logic m2r, input logic rw);
        exec_in       = ex;
        store_data_in = sd;
        write_reg_in  = rd;
        mem_write_in  = mw;
        mem_read_in   = mr;
        mem_to_reg_in = m2r;
        reg_write_in  = rw;
    endtask

    task automatic nop();
        op(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        chk1("rst_req", dmem_req, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk64("rst_wb_data", wb_data, 64'd0);
        chk1("rst_wb_we", wb_reg_write, 1'b0);
        chk1("rst_err", bus_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: ALU op
        op(64'h10, 64'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 chk1("alu_stall", stall, 1'b0);
        tick();
        chk64("alu_wb_data", wb_data, 64'h10);
        chk64("alu_wb_reg", 64'(wb_reg), 64'd5);
        chk1("alu_wb_we", wb_reg_write, 1'b1);
        chk1("alu_fwd", fwd_valid, 1'b1);
        chk1("alu_req", dmem_req, 1'b0);

        // 2: load 0x40, ack on third BUSY cycle
        op(64'h40, 64'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1);
        #1 chk1("ld_stall0", stall, 1'b1);
        chk1("ld_req0", dmem_req, 1'b0);
        tick();
        chk1("ld_req1", dmem_req, 1'b1);
        chk64("ld_addr", dmem_addr, 64'h40);
        chk1("ld_we", dmem_we, 1'b0);
        chk1("ld_bubble1", wb_reg_write, 1'b0);
        chk1("ld_stall1", stall, 1'b1);
        tick();
        chk1("ld_stall2", stall, 1'b1);
        chk1("ld_bubble2", wb_reg_write, 1'b0);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEAD;
        #1 chk1("ld_stall3", stall, 1'b0);
        chk1("ld_req3", dmem_req, 1'b1);
        tick();
        dmem_ack = 1'b0;
        nop();
        chk64("ld_wb_data", wb_data, 64'hDEAD);
        chk64("ld_wb_reg", 64'(wb_reg), 64'd7);
        chk1("ld_wb_we", wb_reg_write, 1'b1);
        chk1("ld_req_done", dmem_req, 1'b0);

        // 3: store 0x08, ack in first BUSY cycle
        op(64'h08, 64'h55, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk1("st_stall0", stall, 1'b1);
        tick();
        chk1("st_req", dmem_req, 1'b1);
        chk1("st_we", dmem_we, 1'b1);
        chk64("st_wdata", dmem_wdata, 64'h55);
        chk64("st_addr", dmem_addr, 64'h08);
        dmem_ack = 1'b1;
        #1 chk1("st_stall1", stall, 1'b0);
        tick();
        dmem_ack = 1'b0;
        nop();
        chk1("st_wb_we", wb_reg_write, 1'b0);
        chk1("st_req_done", dmem_req, 1'b0);
        chk1("st_err", bus_err, 1'b0);

        // Ack on the timeout cycle is a normal completion
        op(64'h10, 64'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hBEEF;
        #1 chk1("tack_req", dmem_req, 1'b1);
        chk1("tack_stall", stall, 1'b0);
        tick();
        dmem_ack = 1'b0;
        nop();
        chk64("tack_wb_data", wb_data, 64'hBEEF);
        chk1("tack_err", bus_err, 1'b0);

        // XZR write is not forwarded
        op(64'h77, 64'd0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk64("xzr_wb_reg", 64'(wb_reg), 64'd31);
        chk1("xzr_wb_we", wb_reg_write, 1'b1);
        chk1("xzr_fwd", fwd_valid, 1'b0);

        // 4: misaligned load
        op(64'h43, 64'd0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1);
        #1 chk1("mis_stall", stall, 1'b0);
        tick();
        nop();
        chk1("mis_req", dmem_req, 1'b0);
        chk1("mis_err", bus_err, 1'b1);
        chk64("mis_wb_data", wb_data, 64'd0);
        chk1("mis_wb_we", wb_reg_write, 1'b1);

        // Reset clears the sticky error
        rst_n = 1'b0;
        #1 chk1("clr_err", bus_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // 5: timeout abort, 4 stall cycles
        op(64'h80, 64'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b1);
        #1 chk1("to_stall0", stall, 1'b1);
        tick();
        chk1("to_stall1", stall, 1'b1);
        tick();
        chk1("to_stall2", stall, 1'b1);
        tick();
        chk1("to_stall3", stall, 1'b1);
        chk1("to_err_early", bus_err, 1'b0);
        tick();
        chk1("to_stall4", stall, 1'b0);
        chk1("to_req4", dmem_req, 1'b1);
        tick();
        nop();
        chk1("to_req_done", dmem_req, 1'b0);
        chk64("to_wb_data", wb_data, 64'd0);
        chk1("to_wb_we", wb_reg_write, 1'b1);
        chk1("to_err", bus_err, 1'b1);

        // 6: reset in the middle of an access
        op(64'h20, 64'd0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk1("mid_req", dmem_req, 1'b1);
        rst_n = 1'b0;
        #1 chk1("mid_rst_req", dmem_req, 1'b0);
        chk1("mid_rst_stall", stall, 1'b0);
        nop();
        tick();
        rst_n = 1'b1;
        tick();
        op(64'h99, 64'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 chk1("post_stall", stall, 1'b0);
        tick();
        nop();
        chk64("post_wb_data", wb_data, 64'h99);
        chk64("post_wb_reg", 64'(wb_reg), 64'd8);
        chk1("post_wb_we", wb_reg_write, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
